// File: rtl/spike_encoder_if.sv
// Image handshake and neuron-array side of the spike encoder.
// master = encoder, slave = image source / neuron array.
interface spike_encoder_if #(
   parameter int N_PIX = 16,
   parameter int PIX_W = 8
);
   logic                     img_valid;
   logic                     img_ready;
   logic [N_PIX*PIX_W-1:0]   pixel_in;
   logic                     start_core_img;
   logic                     start;
   logic [N_PIX-1:0]         spike_out;
   logic                     neuron_done;
   logic [7:0]               step_idx;
   logic                     img_done;
   logic                     busy;

   modport master (
      input  img_valid, pixel_in, neuron_done,
      output img_ready, start_core_img, start, spike_out, step_idx, img_done, busy
   );

   modport slave (
      output img_valid, pixel_in, neuron_done,
      input  img_ready, start_core_img, start, spike_out, step_idx, img_done, busy
   );
endinterface

// File: rtl/spike_encoder.sv
// Rate-coding spike encoder: latches one image, then for T_STEPS steps emits
// one Bernoulli spike per pixel (pixel > LFSR byte) and waits for the neurons.

// One pixel lane: latched intensity, private LFSR, and the next spike bit.
module spike_encoder_lane #(
   parameter int          PIX_W  = 8,
   parameter logic [15:0] SEED_I = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             adv_i,
   input  logic [PIX_W-1:0] pix_i,
   output logic             spike_d_o
);
   logic [PIX_W-1:0] pix_q;
   logic [15:0]      lfsr_q;
   logic [15:0]      lfsr_d;

   // Fibonacci LFSR x^16+x^14+x^13+x^11+1; a non-zero seed never reaches zero.
   assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   // Strictly greater, so intensity 0 never spikes.
   assign spike_d_o = 32'(pix_q) > 32'(lfsr_q[7:0]);

   // Latch pixel and reseed on image accept; advance once per issued step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_q  <= '0;
         lfsr_q <= SEED_I;
      end else if (load_i) begin
         pix_q  <= pix_i;
         lfsr_q <= SEED_I;
      end else if (adv_i) begin
         lfsr_q <= lfsr_d;
      end
   end
endmodule

module spike_encoder #(
   parameter int          N_PIX   = 16,
   parameter int          PIX_W   = 8,
   parameter int          T_STEPS = 100,
   parameter logic [15:0] SEED    = 16'hACE1
) (
   input  logic            clk,
   input  logic            rst,
   spike_encoder_if.master bus
);
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STEP, S_WAIT, S_DONE} state_t;

   localparam logic [7:0] LAST_STEP = 8'(T_STEPS - 1);

   state_t           state_q;
   logic             ready_q, core_q, start_q, done_q, busy_q;
   logic [N_PIX-1:0] spike_q;
   logic [7:0]       idx_q;
   logic [N_PIX-1:0] spike_d;
   logic             load, adv;

   assign load = (state_q == S_IDLE) && bus.img_valid;
   assign adv  = (state_q == S_STEP);

   for (genvar i = 0; i < N_PIX; i++) begin : g_lane
      localparam logic [15:0] S_RAW = SEED ^ 16'(i);
      localparam logic [15:0] S_I   = (S_RAW == 16'h0000) ? 16'hACE1 : S_RAW;
      spike_encoder_lane #(.PIX_W(PIX_W), .SEED_I(S_I)) u_lane (
         .clk       (clk),
         .rst       (rst),
         .load_i    (load),
         .adv_i     (adv),
         .pix_i     (bus.pixel_in[i*PIX_W +: PIX_W]),
         .spike_d_o (spike_d[i])
      );
   end

   // Control FSM; every output is registered alongside the state it belongs to,
   // so spike_out is loaded on the same edge that raises start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ready_q <= 1'b1;
         core_q  <= 1'b0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         spike_q <= '0;
         idx_q   <= '0;
      end else begin
         core_q  <= 1'b0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            S_IDLE: if (bus.img_valid) begin
               state_q <= S_LOAD;
               ready_q <= 1'b0;
               busy_q  <= 1'b1;
               core_q  <= 1'b1;
               idx_q   <= '0;
            end
            S_LOAD: begin
               state_q <= S_STEP;
               start_q <= 1'b1;
               spike_q <= spike_d;
            end
            // done during STEP is deliberately not looked at
            S_STEP: state_q <= S_WAIT;
            S_WAIT: if (bus.neuron_done) begin
               if (idx_q == LAST_STEP) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  spike_q <= '0;
               end else begin
                  state_q <= S_STEP;
                  idx_q   <= idx_q + 8'd1;
                  start_q <= 1'b1;
                  spike_q <= spike_d;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.img_ready      = ready_q;
   assign bus.start_core_img = core_q;
   assign bus.start          = start_q;
   assign bus.spike_out      = spike_q;
   assign bus.step_idx       = idx_q;
   assign bus.img_done       = done_q;
   assign bus.busy           = busy_q;
endmodule

// File: doc/spike_encoder.md
Name: spike_encoder

Overview:
- Rate-coding front end that sits directly upstream of the input neuron array.
- Accepts one image of N_PIX 8-bit pixel intensities through a valid/ready handshake, then runs T_STEPS time steps.
- Each step it emits one Bernoulli spike per pixel (pixel intensity compared against a per-pixel LFSR) with a one-cycle start pulse, and waits for the neurons' done.
- Pulses start_core_img at the beginning of each image so the neurons reset their spike-age counters.

Parameters:
N_PIX, 16, number of pixels / input neurons driven in parallel
PIX_W, 8, pixel intensity width
T_STEPS, 100, time steps per image (1..255)
SEED, 16'hACE1, base LFSR seed; pixel i seeded with SEED ^ i (if the result is 0, use 16'hACE1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
img_valid  input  1  pixel_in holds a valid image
img_ready  output  1  encoder can accept an image (high only in IDLE)
pixel_in  input  N_PIX*PIX_W  packed pixels, pixel i = bits [i*PIX_W +: PIX_W]
start_core_img  output  1  one-cycle pulse: new image, neurons reset spike age
start  output  1  one-cycle pulse: spike_out valid, neurons sample it
spike_out  output  N_PIX  per-pixel spike for current step, one bit per input neuron spike_in
neuron_done  input  1  AND of all input-neuron done outputs
step_idx  output  8  index of current/last issued step (0..T_STEPS-1)
img_done  output  1  one-cycle pulse after the final step's neuron_done
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: img_ready=1, start_core_img=0, start=0, spike_out=0, step_idx=0, img_done=0, busy=0, FSM=IDLE, pixel regs=0, LFSR i = seed i.
- rst asserted mid-image aborts immediately: all outputs return to reset values, no img_done.
- States:
  - IDLE: img_ready=1. On img_valid=1, latch pixel_in, reload all LFSRs to their seeds, step_idx<=0, go LOAD.
  - LOAD: one cycle; start_core_img=1; go STEP.
  - STEP: one cycle; start=1.
    - spike_out[i] = (pix_i > lfsr_i[7:0]), strictly greater, registered so spike_out and start rise in the same cycle.
    - All LFSRs advance one shift at the end of this cycle. Go WAIT.
  - WAIT: spike_out held stable, start=0.
    - On neuron_done=1: if step_idx==T_STEPS-1, go DONE; else step_idx<=step_idx+1, go STEP.
  - DONE: one cycle; img_done=1, spike_out<=0; go IDLE.
- Latency:
  - Handshake cycle -> start_core_img next cycle -> first start the cycle after.
  - With neuron_done returning 1 cycle after start, each step takes 2 cycles; total image = 2 + 2*T_STEPS + 1 cycles.
- Handshake and done rules:
  - neuron_done sampled only in WAIT; a done coincident with start (STEP) is ignored.
  - img_valid outside IDLE is ignored; pixel_in need not be held after acceptance.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - Shift: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - Never enters the all-zero state. Step k of an image uses LFSR state k after the seed.
- Boundaries:
  - Pixel 0 never spikes.
  - Pixel 255 spikes unless lfsr[7:0]==8'hFF.
  - T_STEPS=1 gives exactly one start then img_done.
  - step_idx never exceeds T_STEPS-1.
  - neuron_done stuck low keeps the FSM in WAIT indefinitely, with busy=1 and no timeout.

Test Plan:
1. Reset check: assert rst mid-WAIT -> next cycle all outputs at reset values, img_ready=1, no img_done pulse.
2. All pixels 0, T_STEPS=4, neuron_done returned 1 cycle after each start:
   - start_core_img at cycle 1 after acceptance; start pulses at cycles 2,4,6,8.
   - spike_out always 0; img_done at cycle 10.
3. All pixels 255, T_STEPS=100:
   - spike_out[i]=1 on every step except where the reference-model lfsr_i[7:0]==FF.
   - Compare bit-exactly against a software LFSR model seeded SEED^i.
4. Mixed pixels (pixel i = i*16), 100 steps:
   - Per-pixel spike count matches the model exactly and is roughly proportional to intensity.
   - Second identical image reproduces identical spikes (LFSR reload).
5. Delayed neuron_done (5 cycles late), plus a spurious neuron_done during STEP:
   - spike_out stable throughout WAIT; the spurious done is ignored; step_idx increments once per step.
6. img_valid held high continuously: images accepted only in IDLE, back-to-back; start_core_img once per image; img_ready=0 while busy.
